// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the RISC-V datapath.
//
// Instruction fetch and load/store share one single-port memory through a
// req/ack handshake. The sequencer produces the IR, register-file and PC write
// strobes. It halts in FAULT on an illegal decode or on a memory timeout.
//
// Optional feature: define INSTRET_EN to add a 64-bit retired-instruction
// counter output (instret) that counts cycles with pc_we=1.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   r_en .. auipc_en       decoder class enables (one-hot when legal)
//   branch                 branch condition result
//   mem_ack                memory completes the current request this cycle
//   mem_req/mem_we         memory request / request is a store
//   mem_fetch              address from pc (1) or alu_out (0)
//   ir_we, reg_we, pc_we   datapath write strobes
//   pc_sel                 0 = pc+4, 1 = alu_out
//   fault, fault_code      halted flag; 0 none, 1 illegal decode, 2 timeout
//   state                  current state, for debug
//   instret                (INSTRET_EN only) retired-instruction count
module cpu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TIMEOUT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_en,
    input  logic        i_en,
    input  logic        im_en,
    input  logic        s_en,
    input  logic        b_en,
    input  logic        jal_en,
    input  logic        jalr_en,
    input  logic        lui_en,
    input  logic        auipc_en,
    input  logic        branch,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_fetch,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state
`ifdef INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    typedef enum logic [2:0] {
        StBoot   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StFault  = 3'd7
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TimeoutLast =
        TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [1:0]           fault_code_q, fault_code_d;

    logic [8:0] cls;
    logic       cls_onehot;
    logic       timeout_hit;

    assign cls = {r_en, i_en, im_en, s_en, b_en, jal_en, jalr_en, lui_en, auipc_en};
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign cls_onehot = (cls != 9'd0) && ((cls & (cls - 9'd1)) == 9'd0);
    // wait_q counts completed ack-less request cycles, so the current cycle is
    // the MEM_TIMEOUT-th when wait_q == MEM_TIMEOUT-1.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == TimeoutLast);

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        fault_code_d = fault_code_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_fetch    = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        fault        = 1'b0;
        case (state_q)
            StBoot: begin
                state_d = StFetch;
                wait_d  = '0;
            end
            StFetch: begin
                mem_req   = 1'b1;
                mem_fetch = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    wait_d  = '0;
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    fault_code_d = 2'd2;
                    state_d      = StFault;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                if (!cls_onehot) begin
                    fault_code_d = 2'd1;
                    state_d      = StFault;
                end else if (im_en || s_en) begin
                    wait_d  = '0;
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                pc_we   = 1'b1;
                reg_we  = r_en | i_en | jal_en | jalr_en | lui_en | auipc_en;
                pc_sel  = jal_en | jalr_en | (b_en & branch);
                wait_d  = '0;
                state_d = StFetch;
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = s_en;
                if (mem_ack) begin
                    pc_we   = 1'b1;
                    reg_we  = im_en;
                    wait_d  = '0;
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    fault_code_d = 2'd2;
                    state_d      = StFault;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StFault: begin
                fault = 1'b1;
            end
            default: begin
                // Unused encodings restart the sequencer cleanly.
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBoot;
            wait_q       <= '0;
            fault_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            fault_code_q <= fault_code_d;
        end
    end

`ifdef INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (pc_we) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

    assign fault_code = fault_code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (default parameters,
// MEM_TIMEOUT = 16). Output vector order in the checks:
// {mem_req, mem_we, mem_fetch, ir_we, reg_we, pc_we, pc_sel, fault}.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        r_en, i_en, im_en, s_en, b_en, jal_en, jalr_en, lui_en, auipc_en;
    logic        branch;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_fetch, ir_we, reg_we, pc_we, pc_sel, fault;
    logic [1:0]  fault_code;
    logic [2:0]  state;
`ifdef INSTRET_EN
    logic [63:0] instret;
`endif
    logic [7:0]  outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Class vector order {r, i, im, s, b, jal, jalr, lui, auipc}.
    localparam logic [8:0] CR    = 9'b100000000;
    localparam logic [8:0] CI    = 9'b010000000;
    localparam logic [8:0] CIM   = 9'b001000000;
    localparam logic [8:0] CS    = 9'b000100000;
    localparam logic [8:0] CB    = 9'b000010000;
    localparam logic [8:0] CJAL  = 9'b000001000;
    localparam logic [8:0] CJALR = 9'b000000100;
    localparam logic [8:0] CLUI  = 9'b000000010;
    localparam logic [8:0] CAUI  = 9'b000000001;

    cpu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .r_en       (r_en),
        .i_en       (i_en),
        .im_en      (im_en),
        .s_en       (s_en),
        .b_en       (b_en),
        .jal_en     (jal_en),
        .jalr_en    (jalr_en),
        .lui_en     (lui_en),
        .auipc_en   (auipc_en),
        .branch     (branch),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_fetch  (mem_fetch),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
`ifdef INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    assign outs = {mem_req, mem_we, mem_fetch, ir_we, reg_we, pc_we, pc_sel, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cls(input logic [8:0] c);
        {r_en, i_en, im_en, s_en, b_en, jal_en, jalr_en, lui_en, auipc_en} = c;
    endtask

    // Drive ack for one cycle, check state and outputs mid-cycle, then advance.
    task automatic cyc(input string tag, input logic ack, input logic [2:0] exp_st,
                       input logic [7:0] exp_o);
        mem_ack = ack;
        #1;
        check({tag, "_state"}, 64'(state), 64'(exp_st));
        check({tag, "_outs"}, 64'(outs), 64'(exp_o));
        @(posedge clk);
        #1;
    endtask

    task automatic alu_instr(input string tag, input logic [8:0] c, input logic br,
                             input logic [7:0] exp_exec);
        set_cls(c);
        branch = br;
        cyc({tag, "_fetch"}, 1'b1, 3'd1, 8'hB0);
        cyc({tag, "_dec"}, 1'b1, 3'd2, 8'h00);
        cyc({tag, "_exec"}, 1'b1, 3'd3, exp_exec);
    endtask

    task automatic mem_instr(input string tag, input logic [8:0] c, input int waits,
                             input logic [7:0] exp_wait, input logic [7:0] exp_ack);
        set_cls(c);
        cyc({tag, "_fetch"}, 1'b1, 3'd1, 8'hB0);
        cyc({tag, "_dec"}, 1'b1, 3'd2, 8'h00);
        for (int k = 0; k < waits; k++) cyc({tag, "_wait"}, 1'b0, 3'd4, exp_wait);
        cyc({tag, "_ack"}, 1'b1, 3'd4, exp_ack);
    endtask

    initial begin
        rst     = 1'b1;
        mem_ack = 1'b1;
        branch  = 1'b0;
        set_cls(9'd0);
        @(posedge clk);
        #1;

        // Two reset cycles, ack held high.
        cyc("rst", 1'b1, 3'd0, 8'h00);
        check("rst_code", 64'(fault_code), 64'd0);
        rst = 1'b0;
        cyc("boot", 1'b1, 3'd0, 8'h00);

        // ALU and control-flow classes, ack on first request cycle.
        alu_instr("r1", CR, 1'b0, 8'h0C);
        alu_instr("r2", CR, 1'b0, 8'h0C);
        mem_instr("ld", CIM, 3, 8'h80, 8'h8C);
        alu_instr("bnt", CB, 1'b0, 8'h04);
        alu_instr("bt", CB, 1'b1, 8'h06);
        alu_instr("jalr", CJALR, 1'b0, 8'h0E);
        alu_instr("jal", CJAL, 1'b0, 8'h0E);
        alu_instr("lui", CLUI, 1'b0, 8'h0C);
        alu_instr("auipc", CAUI, 1'b0, 8'h0C);
        alu_instr("imm", CI, 1'b0, 8'h0C);
        mem_instr("st0", CS, 0, 8'hC0, 8'hC4);
        mem_instr("st2", CS, 2, 8'hC0, 8'hC4);

        // Ack on the 16th request cycle wins over the timeout.
        set_cls(CR);
        for (int k = 0; k < 15; k++) cyc("to_wait", 1'b0, 3'd1, 8'hA0);
        cyc("to_ack16", 1'b1, 3'd1, 8'hB0);
        cyc("to_dec", 1'b1, 3'd2, 8'h00);
        cyc("to_exec", 1'b1, 3'd3, 8'h0C);
        // No ack for 16 request cycles: timeout fault.
        for (int k = 0; k < 16; k++) cyc("to_nack", 1'b0, 3'd1, 8'hA0);
        check("to_code", 64'(fault_code), 64'd2);
        cyc("to_fault", 1'b1, 3'd7, 8'h01);
        rst = 1'b1;
        cyc("to_rst", 1'b1, 3'd7, 8'h01);
        rst = 1'b0;
        check("to_rst_code", 64'(fault_code), 64'd0);
        cyc("to_boot", 1'b1, 3'd0, 8'h00);

        // Illegal decode: no class enable.
        set_cls(9'd0);
        cyc("ill_fetch", 1'b1, 3'd1, 8'hB0);
        cyc("ill_dec", 1'b1, 3'd2, 8'h00);
        check("ill_code", 64'(fault_code), 64'd1);
        for (int k = 0; k < 20; k++) cyc("ill_hold", 1'b1, 3'd7, 8'h01);
        check("ill_code_held", 64'(fault_code), 64'd1);
        rst = 1'b1;
        cyc("ill_rst", 1'b1, 3'd7, 8'h01);
        rst = 1'b0;
        cyc("ill_boot", 1'b1, 3'd0, 8'h00);

        // Illegal decode: two class enables.
        set_cls(CR | CS);
        cyc("two_fetch", 1'b1, 3'd1, 8'hB0);
        cyc("two_dec", 1'b1, 3'd2, 8'h00);
        cyc("two_fault", 1'b1, 3'd7, 8'h01);
        check("two_code", 64'(fault_code), 64'd1);
        rst = 1'b1;
        cyc("two_rst", 1'b1, 3'd7, 8'h01);
        rst = 1'b0;
        check("two_rst_code", 64'(fault_code), 64'd0);
        cyc("two_boot", 1'b1, 3'd0, 8'h00);

        // 5 ALU ops + 2 stores since the last reset.
        for (int k = 0; k < 5; k++) alu_instr("cnt_alu", CR, 1'b0, 8'h0C);
        mem_instr("cnt_st", CS, 0, 8'hC0, 8'hC4);
        mem_instr("cnt_st", CS, 1, 8'hC0, 8'hC4);
`ifdef INSTRET_EN
        check("instret_7", instret, 64'd7);
`endif

        // Reset during a MEM wait; the late ack must be ignored.
        set_cls(CIM);
        cyc("mr_fetch", 1'b1, 3'd1, 8'hB0);
        cyc("mr_dec", 1'b1, 3'd2, 8'h00);
        cyc("mr_wait", 1'b0, 3'd4, 8'h80);
        rst = 1'b1;
        cyc("mr_rst", 1'b0, 3'd4, 8'h80);
        rst = 1'b0;
        cyc("mr_late_ack", 1'b1, 3'd0, 8'h00);
`ifdef INSTRET_EN
        check("instret_rst", instret, 64'd0);
`endif
        cyc("mr_refetch", 1'b1, 3'd1, 8'hB0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
